// File: rtl/zx81_tape_player.sv
// zx81_tape_player: encodes a byte stream MSB-first into the ZX81 cassette pulse train on ear.
// Latency: ear rises the cycle after a byte is accepted; a bit is 8 or 18 half-pulses plus one gap.
// Backpressure: byte_ready only in LOAD, one byte held at a time; a stall stretches the inter-byte gap.
// Optional feature macro ZX81_TAPE_LEADER_EN: adds a LEADER_CYC low leader between start and the first byte.
module zx81_tape_player #(
   parameter int PULSE_CYC  = 7500,
   parameter int GAP_CYC    = 65000
`ifdef ZX81_TAPE_LEADER_EN
   ,
   parameter int LEADER_CYC = 50000000
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] byte_data,
   input  logic       byte_last,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       ear,
   output logic       busy,
   output logic       done,
   output logic       stall
);

   localparam logic [2:0] S_IDLE     = 3'd0;
`ifdef ZX81_TAPE_LEADER_EN
   localparam logic [2:0] S_LEADER   = 3'd1;
`endif
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_PULSE_HI = 3'd3;
   localparam logic [2:0] S_PULSE_LO = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;

   logic [2:0]  state;
   logic [31:0] cyc_cnt;    // cycles left in the current timed state, ends at 1
   logic [3:0]  pulse_cnt;  // pulses left in the current bit
   logic [2:0]  bit_idx;    // bits left after the one being sent
   logic [6:0]  shift_dat;  // remaining bits of the byte, next bit in [6]
   logic        last_flag;
   logic        done_r;
   logic        cyc_end;

   assign cyc_end    = (cyc_cnt == 32'd1);
   assign byte_ready = (state == S_LOAD);
   assign ear        = (state == S_PULSE_HI);
   assign busy       = (state != S_IDLE);
   assign stall      = (state == S_LOAD) && !byte_valid;
   assign done       = done_r;

   // Playback state machine: stop aborts from anywhere, reset overrides everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         cyc_cnt   <= 32'd0;
         pulse_cnt <= 4'd0;
         bit_idx   <= 3'd0;
         shift_dat <= 7'd0;
         last_flag <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (stop) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
`ifdef ZX81_TAPE_LEADER_EN
                     state   <= S_LEADER;
                     cyc_cnt <= 32'(LEADER_CYC);
`else
                     state   <= S_LOAD;
`endif
                  end
               end
`ifdef ZX81_TAPE_LEADER_EN
               S_LEADER: begin
                  if (cyc_end) state <= S_LOAD;
                  else         cyc_cnt <= cyc_cnt - 32'd1;
               end
`endif
               S_LOAD: begin
                  if (byte_valid) begin
                     shift_dat <= byte_data[6:0];
                     last_flag <= byte_last;
                     bit_idx   <= 3'd7;
                     pulse_cnt <= byte_data[7] ? 4'd9 : 4'd4;
                     cyc_cnt   <= 32'(PULSE_CYC);
                     state     <= S_PULSE_HI;
                  end
               end
               S_PULSE_HI: begin
                  if (cyc_end) begin
                     cyc_cnt <= 32'(PULSE_CYC);
                     state   <= S_PULSE_LO;
                  end else begin
                     cyc_cnt <= cyc_cnt - 32'd1;
                  end
               end
               S_PULSE_LO: begin
                  if (cyc_end) begin
                     pulse_cnt <= pulse_cnt - 4'd1;
                     if (pulse_cnt > 4'd1) begin
                        cyc_cnt <= 32'(PULSE_CYC);
                        state   <= S_PULSE_HI;
                     end else begin
                        cyc_cnt <= 32'(GAP_CYC);
                        state   <= S_GAP;
                     end
                  end else begin
                     cyc_cnt <= cyc_cnt - 32'd1;
                  end
               end
               S_GAP: begin
                  if (cyc_end) begin
                     if (bit_idx != 3'd0) begin
                        bit_idx   <= bit_idx - 3'd1;
                        shift_dat <= {shift_dat[5:0], 1'b0};
                        pulse_cnt <= shift_dat[6] ? 4'd9 : 4'd4;
                        cyc_cnt   <= 32'(PULSE_CYC);
                        state     <= S_PULSE_HI;
                     end else if (last_flag) begin
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                     end else begin
                        state <= S_LOAD;
                     end
                  end else begin
                     cyc_cnt <= cyc_cnt - 32'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_zx81_tape_player.sv
// tb_zx81_tape_player: directed checks of the ZX81 tape pulse encoder with PULSE_CYC=2, GAP_CYC=5.
// A negedge monitor logs ear rises, handshakes and done; a small model rebuilds the rise schedule.
// Half-pulse = 2 cycles, so a pulse is 4 cycles, a 0 bit 21 cycles and a 1 bit 41 cycles.
module tb_zx81_tape_player;

   logic       clock = 1'b0;
   logic       reset, start, stop, byte_last, byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready, ear, busy, done, stall;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef ZX81_TAPE_LEADER_EN
   localparam int START_LAT = 11;
`else
   localparam int START_LAT = 1;
`endif

   always #5 clock = ~clock;

   zx81_tape_player #(
      .PULSE_CYC (2),
      .GAP_CYC   (5)
`ifdef ZX81_TAPE_LEADER_EN
      ,
      .LEADER_CYC(10)
`endif
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .byte_data (byte_data),
      .byte_last (byte_last),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .ear       (ear),
      .busy      (busy),
      .done      (done),
      .stall     (stall)
   );

   // Mid-cycle monitor state
   int   cyc = 0;
   logic ear_q = 1'b0;
   int   hi_run = 0;
   int   bad_hi = 0;
   int   ready_cnt = 0;
   int   stall_cnt = 0;
   int   stall_ear = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   done_busy = 0;
   int   start_cyc = 0;
   int   rise_q[$];
   int   hs_q[$];

   // Sample DUT outputs at the falling edge, away from the active edge
   always @(negedge clock) begin
      cyc++;
      if (ear && !ear_q) rise_q.push_back(cyc);
      if (ear) hi_run++;
      else begin
         if (ear_q && hi_run != 2) bad_hi++;
         hi_run = 0;
      end
      ear_q = ear;
      if (byte_ready) ready_cnt++;
      if (byte_ready && byte_valid) hs_q.push_back(cyc);
      if (stall) stall_cnt++;
      if (stall && ear) stall_ear++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (done && busy) done_busy++;
      if (start && !busy && !reset) start_cyc = cyc;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a byte (optionally after holding valid low for stall_cyc LOAD cycles) and wait for the handshake
   task automatic send(input logic [7:0] b, input logic last, input int stall_cyc, output bit ok);
      int k;
      ok = 1'b1;
      if (stall_cyc > 0) begin
         byte_valid = 1'b0;
         k = 0;
         do begin @(negedge clock); k++; end while (!byte_ready && k < 3000);
         if (!byte_ready) begin
            ok = 1'b0;
            return;
         end
         repeat (stall_cyc - 1) @(negedge clock);
         tick();
      end
      byte_data  = b;
      byte_last  = last;
      byte_valid = 1'b1;
      k = 0;
      do begin @(negedge clock); k++; end while (!byte_ready && k < 3000);
      ok = byte_ready;
      tick();
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check(tag, done, 1);
      tick();
   endtask

   // Rebuild the expected rise times of one byte starting the cycle after its handshake
   task automatic check_sched(input string tag, input logic [7:0] b, input int hs, inout int idx);
      int t, errs, n;
      t = hs + 1;
      errs = 0;
      for (int i = 7; i >= 0; i--) begin
         n = b[i] ? 9 : 4;
         for (int p = 0; p < n; p++) begin
            if (idx >= rise_q.size() || rise_q[idx] != t) errs++;
            idx++;
            t += 4;
         end
         t += 5;
      end
      check(tag, errs, 0);
   endtask

   initial begin
      bit ok;
      int rb, hb, dc, rc, sc, se, bh, idx, k, errs;

      reset = 1'b1; start = 1'b0; stop = 1'b0;
      byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
      repeat (3) tick();
      check("rst_ear", ear, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall, 0);
      reset = 1'b0;
      tick();

      // Single 0x00 byte, last, valid held high
      rb = rise_q.size(); hb = hs_q.size(); dc = done_cnt; bh = bad_hi;
      byte_data = 8'h00; byte_last = 1'b1; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'h00, 1'b1, 0, ok);
      check("s1_accept", ok, 1);
      byte_valid = 1'b0;
      wait_done("s1_done");
      check("s1_rises", rise_q.size() - rb, 32);
      check("s1_hi_len", bad_hi - bh, 0);
      check("s1_start_lat", hs_q[hb] - start_cyc, START_LAT);
      check("s1_ear_lat", rise_q[rb] - hs_q[hb], 1);
      idx = rb;
      check_sched("s1_sched", 8'h00, hs_q[hb], idx);
      check("s1_done_lat", done_cyc - rise_q[rb], 168);
      check("s1_done_cnt", done_cnt - dc, 1);

      // Single 0xFF byte, last
      rb = rise_q.size(); hb = hs_q.size(); bh = bad_hi;
      byte_data = 8'hFF; byte_last = 1'b1; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'hFF, 1'b1, 0, ok);
      check("s2_accept", ok, 1);
      byte_valid = 1'b0;
      wait_done("s2_done");
      check("s2_rises", rise_q.size() - rb, 72);
      check("s2_hi_len", bad_hi - bh, 0);
      idx = rb;
      check_sched("s2_sched", 8'hFF, hs_q[hb], idx);
      check("s2_done_lat", done_cyc - rise_q[rb], 328);

      // 0x80 then 0x01 (last), valid always high
      rb = rise_q.size(); hb = hs_q.size(); rc = ready_cnt; dc = done_cnt;
      byte_data = 8'h80; byte_last = 1'b0; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'h80, 1'b0, 0, ok);
      check("s3_accept0", ok, 1);
      send(8'h01, 1'b1, 0, ok);
      check("s3_accept1", ok, 1);
      byte_valid = 1'b0;
      wait_done("s3_done");
      check("s3_rises", rise_q.size() - rb, 74);
      check("s3_ready_cyc", ready_cnt - rc, 2);
      check("s3_byte_gap", hs_q[hb + 1] - hs_q[hb], 189);
      idx = rb;
      check_sched("s3_sched0", 8'h80, hs_q[hb], idx);
      check_sched("s3_sched1", 8'h01, hs_q[hb + 1], idx);
      check("s3_done_cnt", done_cnt - dc, 1);

      // Stall: valid low for 20 LOAD cycles between 0x40 and 0x00 (last)
      rb = rise_q.size(); hb = hs_q.size(); sc = stall_cnt; se = stall_ear;
      byte_data = 8'h40; byte_last = 1'b0; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'h40, 1'b0, 0, ok);
      check("s4_accept0", ok, 1);
      send(8'h00, 1'b1, 20, ok);
      check("s4_accept1", ok, 1);
      byte_valid = 1'b0;
      wait_done("s4_done");
      check("s4_stall_cyc", stall_cnt - sc, 20);
      check("s4_stall_ear", stall_ear - se, 0);
      check("s4_byte_gap", hs_q[hb + 1] - hs_q[hb], 209);
      check("s4_rises", rise_q.size() - rb, 69);
      idx = rb;
      check_sched("s4_sched0", 8'h40, hs_q[hb], idx);
      check_sched("s4_sched1", 8'h00, hs_q[hb + 1], idx);

      // stop while ear is high, then replay a fresh byte
      dc = done_cnt;
      byte_data = 8'hFF; byte_last = 1'b0; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'hFF, 1'b0, 0, ok);
      check("s5_accept", ok, 1);
      byte_valid = 1'b0;
      repeat (7) tick();
      k = 0;
      while (!ear && k < 100) begin tick(); k++; end
      check("s5_mid_pulse", ear, 1);
      stop = 1'b1; tick(); stop = 1'b0;
      check("s5_ear", ear, 0);
      check("s5_busy", busy, 0);
      check("s5_done", done, 0);
      repeat (10) tick();
      check("s5_no_done", done_cnt - dc, 0);
      rb = rise_q.size(); hb = hs_q.size();
      byte_data = 8'h00; byte_last = 1'b1; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'h00, 1'b1, 0, ok);
      check("s5_replay_accept", ok, 1);
      byte_valid = 1'b0;
      wait_done("s5_replay_done");
      check("s5_replay_rises", rise_q.size() - rb, 32);
      idx = rb;
      check_sched("s5_replay_sched", 8'h00, hs_q[hb], idx);

      // reset (with start asserted) while ear is high, then replay 0x3C
      dc = done_cnt;
      byte_data = 8'hFF; byte_last = 1'b0; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'hFF, 1'b0, 0, ok);
      check("s6_accept", ok, 1);
      byte_valid = 1'b0;
      repeat (5) tick();
      k = 0;
      while (!ear && k < 100) begin tick(); k++; end
      check("s6_mid_pulse", ear, 1);
      reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
      check("s6_ear", ear, 0);
      check("s6_busy", busy, 0);
      check("s6_done", done, 0);
      stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
      check("s6_stop_wins", busy, 0);
      repeat (5) tick();
      check("s6_no_done", done_cnt - dc, 0);
      rb = rise_q.size(); hb = hs_q.size();
      byte_data = 8'h3C; byte_last = 1'b1; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      send(8'h3C, 1'b1, 0, ok);
      check("s6_replay_accept", ok, 1);
      byte_valid = 1'b0;
      wait_done("s6_replay_done");
      check("s6_replay_rises", rise_q.size() - rb, 52);
      check("s6_replay_done_lat", done_cyc - rise_q[rb], 248);
      idx = rb;
      check_sched("s6_replay_sched", 8'h3C, hs_q[hb], idx);

`ifdef ZX81_TAPE_LEADER_EN
      // Leader: 10 low cycles without byte_ready; a start pulse inside it is ignored
      hb = hs_q.size();
      byte_data = 8'h00; byte_last = 1'b1; byte_valid = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      errs = 0;
      for (int i = 1; i <= 10; i++) begin
         if (ear || byte_ready) errs++;
         start = (i == 4);
         tick();
      end
      start = 1'b0;
      check("ld_quiet", errs, 0);
      check("ld_ready", byte_ready, 1);
      send(8'h00, 1'b1, 0, ok);
      check("ld_accept", ok, 1);
      byte_valid = 1'b0;
      wait_done("ld_done");
      check("ld_hs_lat", hs_q[hb] - start_cyc, 11);
`endif

      check("done_with_busy", done_busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
